// File: rtl/sa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared types and sizing helpers for the systolic array controller.
//   sa_state_t  : pass sequencing states
//   step_w()    : width of the skew step counter / operand read address
//   step_count(): number of skewed operand steps T for a given K
// -----------------------------------------------------------------------------
package sa_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      COMPUTE = 3'd2,
      READOUT = 3'd3,
      FINISH  = 3'd4
   } sa_state_t;

   // Step index reaches 2^KW + ROWS + COLS - 3, so widen by log2(ROWS+COLS).
   function automatic int unsigned step_w(input int unsigned kw,
                                          input int unsigned rows,
                                          input int unsigned cols);
      return kw + $clog2(rows + cols);
   endfunction

   // Skewed wavefront needs K steps plus ROWS-1 and COLS-1 steps of fill/drain.
   function automatic int unsigned step_count(input int unsigned k,
                                              input int unsigned rows,
                                              input int unsigned cols);
      return k + rows + cols - 2;
   endfunction

endpackage

// File: rtl/sa_skew_mask.sv
// -----------------------------------------------------------------------------
// sa_skew_mask
// Lane-valid mask for one skewed operand edge of the PE array. Lane i is fed
// operand index t-i, which is real data only while 0 <= t-i < K.
//   i_t    : current skew step index
//   i_k    : inner dimension length K
//   o_mask : bit i set when lane i carries real data
// -----------------------------------------------------------------------------
module sa_skew_mask #(
   parameter int unsigned N  = 4,
   parameter int unsigned TW = 11,
   parameter int unsigned KW = 8
) (
   input  logic [TW-1:0] i_t,
   input  logic [KW-1:0] i_k,
   output logic [N-1:0]  o_mask
);

   // The t >= i term guards the subtraction against wrap-around.
   always_comb begin
      o_mask = '0;
      for (int i = 0; i < int'(N); i++) begin
         o_mask[i] = (i_t >= TW'(i)) && ((i_t - TW'(i)) < TW'(i_k));
      end
   end

endmodule

// File: rtl/systolic_array_controller.sv
// -----------------------------------------------------------------------------
// systolic_array_controller
// Sequences one matrix-multiply pass on a ROWS x COLS MAC array: clear the
// accumulators, stream K skewed operand steps (stalling on OP_VALID), then
// hand the result rows out over a valid/ready handshake.
//
// Optional feature macro: SA_CTRL_PERF_CNT_EN adds the STALL_CNT output.
//
// Ports:
//   CLK, SYNC_RST   clock, synchronous active-high reset
//   START, K_LEN    pass request (IDLE only) and inner dimension K
//   BUSY, DONE      not-idle flag, one-cycle completion pulse
//   OP_RD_EN/ADDR   operand buffer read request and skew step index
//   OP_VALID        operand data for the current step is present
//   ROW_MASK        per-row input lane valid mask
//   COL_MASK        per-column weight lane valid mask
//   ARR_EN, ARR_CLR PE array enable and accumulator clear
//   RES_ROW/VALID   result row index and valid
//   RES_READY       downstream accepts the presented result row
//   STALL_CNT       (macro only) saturating count of COMPUTE stall cycles
// -----------------------------------------------------------------------------
module systolic_array_controller
   import sa_ctrl_pkg::*;
#(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4,
   parameter int unsigned KW   = 8
) (
   input  logic                               CLK,
   input  logic                               SYNC_RST,
   input  logic                               START,
   input  logic [KW-1:0]                      K_LEN,
   output logic                               BUSY,
   output logic                               DONE,
   output logic                               OP_RD_EN,
   output logic [step_w(KW, ROWS, COLS)-1:0]  OP_RD_ADDR,
   input  logic                               OP_VALID,
   output logic [ROWS-1:0]                    ROW_MASK,
   output logic [COLS-1:0]                    COL_MASK,
   output logic                               ARR_EN,
   output logic                               ARR_CLR,
   output logic [$clog2(ROWS)-1:0]            RES_ROW,
   output logic                               RES_VALID,
   input  logic                               RES_READY
`ifdef SA_CTRL_PERF_CNT_EN
   ,
   output logic [15:0]                        STALL_CNT
`endif
);

   localparam int unsigned TW = step_w(KW, ROWS, COLS);
   localparam int unsigned RW = $clog2(ROWS);

   sa_state_t         r_state;
   logic [TW-1:0]     r_t;
   logic [KW-1:0]     r_k;
   logic [RW-1:0]     r_res_row;

   logic [TW-1:0]     w_t_last;
   logic              w_compute;
   logic [ROWS-1:0]   w_row_mask;
   logic [COLS-1:0]   w_col_mask;

   // Index of the final skew step, T-1; only consulted when K > 0.
   assign w_t_last  = TW'(step_count(32'(r_k), ROWS, COLS) - 32'd1);
   assign w_compute = (r_state == COMPUTE);

   // Pass sequencing: state, step counter, captured K and result row.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         r_state   <= IDLE;
         r_t       <= '0;
         r_k       <= '0;
         r_res_row <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_k     <= K_LEN;
                  r_state <= CLEAR;
               end
            end
            CLEAR: begin
               r_t       <= '0;
               r_res_row <= '0;
               r_state   <= (r_k == '0) ? READOUT : COMPUTE;
            end
            COMPUTE: begin
               // A missing operand step freezes t, the masks and the array.
               if (OP_VALID) begin
                  if (r_t == w_t_last) begin
                     r_state <= READOUT;
                  end else begin
                     r_t <= r_t + TW'(1);
                  end
               end
            end
            READOUT: begin
               if (RES_READY) begin
                  if (r_res_row == RW'(ROWS - 1)) begin
                     r_state <= FINISH;
                  end else begin
                     r_res_row <= r_res_row + RW'(1);
                  end
               end
            end
            FINISH: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   sa_skew_mask #(
      .N  (ROWS),
      .TW (TW),
      .KW (KW)
   ) u_row_mask (
      .i_t    (r_t),
      .i_k    (r_k),
      .o_mask (w_row_mask)
   );

   sa_skew_mask #(
      .N  (COLS),
      .TW (TW),
      .KW (KW)
   ) u_col_mask (
      .i_t    (r_t),
      .i_k    (r_k),
      .o_mask (w_col_mask)
   );

   // Array controls decode straight from registered state so they line up
   // with the operand data for step t in the same cycle.
   assign BUSY       = (r_state != IDLE);
   assign DONE       = (r_state == FINISH);
   assign ARR_CLR    = (r_state == CLEAR);
   assign OP_RD_EN   = w_compute;
   assign OP_RD_ADDR = r_t;
   assign ARR_EN     = w_compute && OP_VALID;
   assign ROW_MASK   = w_compute ? w_row_mask : '0;
   assign COL_MASK   = w_compute ? w_col_mask : '0;
   assign RES_VALID  = (r_state == READOUT);
   assign RES_ROW    = r_res_row;

`ifdef SA_CTRL_PERF_CNT_EN
   logic [15:0] r_stall_cnt;

   // Saturating stall counter; restarts on each accepted pass request.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         r_stall_cnt <= '0;
      end else if ((r_state == IDLE) && START) begin
         r_stall_cnt <= '0;
      end else if (w_compute && !OP_VALID && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_array_controller.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_controller
// Self-checking bench: each pass is checked cycle by cycle against a model
// that derives expected lane masks, step addresses and phase ordering from
// the operand-index view of the skewed wavefront.
// -----------------------------------------------------------------------------
module tb_systolic_array_controller;

   logic        CLK;
   logic        SYNC_RST;
   logic        START;
   logic [7:0]  K_LEN;
   logic        BUSY;
   logic        DONE;
   logic        OP_RD_EN;
   logic [10:0] OP_RD_ADDR;
   logic        OP_VALID;
   logic [3:0]  ROW_MASK;
   logic [3:0]  COL_MASK;
   logic        ARR_EN;
   logic        ARR_CLR;
   logic [1:0]  RES_ROW;
   logic        RES_VALID;
   logic        RES_READY;
`ifdef SA_CTRL_PERF_CNT_EN
   logic [15:0] STALL_CNT;
`endif

   int errors = 0;
   int checks = 0;

   int obs_row_q[$];
   int arr_en_cnt;
   int last_stalls;
   int rd_cycles;

   systolic_array_controller #(
      .ROWS (4),
      .COLS (4),
      .KW   (8)
   ) dut (
      .CLK        (CLK),
      .SYNC_RST   (SYNC_RST),
      .START      (START),
      .K_LEN      (K_LEN),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .OP_RD_EN   (OP_RD_EN),
      .OP_RD_ADDR (OP_RD_ADDR),
      .OP_VALID   (OP_VALID),
      .ROW_MASK   (ROW_MASK),
      .COL_MASK   (COL_MASK),
      .ARR_EN     (ARR_EN),
      .ARR_CLR    (ARR_CLR),
      .RES_ROW    (RES_ROW),
      .RES_VALID  (RES_VALID),
      .RES_READY  (RES_READY)
`ifdef SA_CTRL_PERF_CNT_EN
      ,
      .STALL_CNT  (STALL_CNT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   // Lane i sees operand index s-i; it is real data when that index is in [0,K).
   function automatic logic [3:0] exp_mask(input int s, input int k);
      logic [3:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[i] = ((s - i) >= 0) && ((s - i) < k);
      end
      return m;
   endfunction

   task automatic apply_reset();
      SYNC_RST = 1'b1;
      START = 1'b0; OP_VALID = 1'b0; RES_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1 SYNC_RST = 1'b0;
   endtask

   // One full pass. Status vector order: BUSY,DONE,OP_RD_EN,ARR_EN,ARR_CLR,RES_VALID.
   task automatic do_pass(input int k, input int stall_pct, input int stall_at,
                          input int stall_len, input int nready_pct,
                          input int hold_row, input int hold_len,
                          input bit start_mid, input int rst_at, input string tag);
      int  s, stalls, held_s, held_r, r, guard, t_steps;
      bit  ov, rdy, did_start;
      logic [5:0] st;
      t_steps   = k + 4 + 4 - 2;
      obs_row_q.delete();
      arr_en_cnt = 0; stalls = 0; held_s = 0; held_r = 0; did_start = 0;
      rd_cycles  = 0;

      @(posedge CLK); #1;
      START = 1'b1; K_LEN = 8'(k); OP_VALID = 1'b0; RES_READY = 1'b0; #1;
      checks++;
      if (BUSY !== 1'b0) begin
         errors++; $display("FAIL %s idle_busy got=%b exp=0", tag, BUSY);
      end

      @(posedge CLK); #1;
      START = 1'b0; K_LEN = 8'($urandom); #1;
      st = {BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID};
      checks++;
      if (st !== 6'b100010) begin
         errors++; $display("FAIL %s clear_status got=%b exp=%b", tag, st, 6'b100010);
      end

      s = 0; guard = 0;
      if (k > 0) begin
         while (s < t_steps) begin
            @(posedge CLK); #1;
            guard++;
            if (guard > 4000) begin
               checks++; errors++;
               $display("FAIL %s compute_timeout got=step%0d exp=step%0d", tag, s, t_steps);
               apply_reset();
               return;
            end
            if (s == stall_at && held_s < stall_len) begin
               ov = 1'b0; held_s++;
            end else begin
               ov = ($urandom_range(99) >= stall_pct);
            end
            OP_VALID = ov;
            if (start_mid && s == 2 && !did_start) begin
               START = 1'b1; K_LEN = 8'(k + 7); did_start = 1'b1;
            end else begin
               START = 1'b0;
            end
            if (rst_at >= 0 && s == rst_at) SYNC_RST = 1'b1;
            #1;
            st = {BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID};
            checks++;
            if (st !== {4'b1010 | {3'b000, ov}, 2'b00}) begin
               errors++;
               $display("FAIL %s compute_status s=%0d got=%b exp=%b", tag, s, st,
                        {4'b1010 | {3'b000, ov}, 2'b00});
            end
            checks++;
            if (OP_RD_ADDR !== 11'(s)) begin
               errors++; $display("FAIL %s rd_addr got=%0d exp=%0d", tag, OP_RD_ADDR, s);
            end
            checks++;
            if ({ROW_MASK, COL_MASK} !== {exp_mask(s, k), exp_mask(s, k)}) begin
               errors++;
               $display("FAIL %s masks s=%0d got=%b_%b exp=%b_%b", tag, s, ROW_MASK,
                        COL_MASK, exp_mask(s, k), exp_mask(s, k));
            end
            obs_row_q.push_back(int'(ROW_MASK));
            if (ARR_EN === 1'b1) arr_en_cnt++;
            if (SYNC_RST) begin
               @(posedge CLK); #1;
               SYNC_RST = 1'b0; OP_VALID = 1'b0; START = 1'b0; #1;
               checks++;
               if ({BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID, ROW_MASK, COL_MASK,
                    RES_ROW, OP_RD_ADDR} !== '0) begin
                  errors++;
                  $display("FAIL %s midrst_outputs got=%b%b%b%b%b%b rm=%b cm=%b row=%0d addr=%0d exp=all0",
                           tag, BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID, ROW_MASK,
                           COL_MASK, RES_ROW, OP_RD_ADDR);
               end
`ifdef SA_CTRL_PERF_CNT_EN
               checks++;
               if (STALL_CNT !== 16'd0) begin
                  errors++; $display("FAIL %s midrst_stall_cnt got=%0d exp=0", tag, STALL_CNT);
               end
`endif
               repeat (3) begin
                  @(posedge CLK); #1; #1;
                  checks++;
                  if ({BUSY, DONE} !== 2'b00) begin
                     errors++; $display("FAIL %s midrst_idle got=%b exp=00", tag, {BUSY, DONE});
                  end
               end
               return;
            end
            if (ov) s++; else stalls++;
         end
      end
      START = 1'b0;
      last_stalls = stalls;

      r = 0; guard = 0;
      while (r < 4) begin
         @(posedge CLK); #1;
         guard++;
         if (guard > 4000) begin
            checks++; errors++;
            $display("FAIL %s readout_timeout got=row%0d exp=row4", tag, r);
            apply_reset();
            return;
         end
         if (r == hold_row && held_r < hold_len) begin
            rdy = 1'b0; held_r++;
         end else begin
            rdy = ($urandom_range(99) >= nready_pct);
         end
         RES_READY = rdy;
         OP_VALID  = 1'($urandom);
         #1;
         rd_cycles++;
         st = {BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID};
         checks++;
         if (st !== 6'b100001) begin
            errors++; $display("FAIL %s readout_status row=%0d got=%b exp=%b", tag, r, st, 6'b100001);
         end
         checks++;
         if (RES_ROW !== 2'(r)) begin
            errors++; $display("FAIL %s res_row got=%0d exp=%0d", tag, RES_ROW, r);
         end
         if (rdy) r++;
      end

      // START during the DONE pulse must be ignored.
      @(posedge CLK); #1;
      RES_READY = 1'b0; OP_VALID = 1'b0; START = 1'b1; K_LEN = 8'(k + 1); #1;
      st = {BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID};
      checks++;
      if (st !== 6'b110000) begin
         errors++; $display("FAIL %s done_status got=%b exp=%b", tag, st, 6'b110000);
      end
      @(posedge CLK); #1;
      START = 1'b0; #1;
      st = {BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID};
      checks++;
      if (st !== 6'b000000) begin
         errors++; $display("FAIL %s post_done_idle got=%b exp=%b", tag, st, 6'b000000);
      end
`ifdef SA_CTRL_PERF_CNT_EN
      checks++;
      if (STALL_CNT !== 16'(stalls)) begin
         errors++; $display("FAIL %s stall_cnt got=%0d exp=%0d", tag, STALL_CNT, stalls);
      end
`endif
   endtask

   task automatic test_reset();
      SYNC_RST = 1'b1; START = 1'b0; K_LEN = 8'd0; OP_VALID = 1'b0; RES_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID, ROW_MASK, COL_MASK,
           RES_ROW, OP_RD_ADDR} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%b%b%b%b%b%b rm=%b cm=%b row=%0d addr=%0d exp=all0",
                  BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID, ROW_MASK, COL_MASK,
                  RES_ROW, OP_RD_ADDR);
      end
`ifdef SA_CTRL_PERF_CNT_EN
      checks++;
      if (STALL_CNT !== 16'd0) begin
         errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", STALL_CNT);
      end
`endif
      SYNC_RST = 1'b0;
      @(posedge CLK); #2;
      checks++;
      if ({BUSY, DONE, ARR_CLR} !== 3'b000) begin
         errors++; $display("FAIL reset_release got=%b exp=000", {BUSY, DONE, ARR_CLR});
      end
   endtask

   task automatic test_basic();
      int tbl[9];
      tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 0, 0, 0};
      do_pass(3, 0, -1, 0, 0, -1, 0, 1'b0, -1, "basic");
      checks++;
      if (obs_row_q.size() != 9) begin
         errors++; $display("FAIL basic_compute_len got=%0d exp=9", obs_row_q.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs_row_q[i] != tbl[i]) begin
               errors++; $display("FAIL basic_row_seq i=%0d got=%b exp=%b", i, 4'(obs_row_q[i]), 4'(tbl[i]));
            end
         end
      end
      checks++;
      if (arr_en_cnt != 9) begin
         errors++; $display("FAIL basic_arr_en_cnt got=%0d exp=9", arr_en_cnt);
      end
   endtask

   task automatic test_stall();
      do_pass(3, 0, 4, 2, 0, -1, 0, 1'b0, -1, "stall");
      checks++;
      if (obs_row_q.size() != 11) begin
         errors++; $display("FAIL stall_compute_len got=%0d exp=11", obs_row_q.size());
      end else begin
         for (int i = 4; i < 7; i++) begin
            checks++;
            if (obs_row_q[i] != 4'b1100) begin
               errors++; $display("FAIL stall_hold_mask i=%0d got=%b exp=1100", i, 4'(obs_row_q[i]));
            end
         end
      end
      checks++;
      if (arr_en_cnt != 9 || last_stalls != 2) begin
         errors++; $display("FAIL stall_arr_en got=%0d/%0d exp=9/2", arr_en_cnt, last_stalls);
      end
   endtask

   task automatic test_k_zero();
      do_pass(0, 0, -1, 0, 0, -1, 0, 1'b0, -1, "kzero");
      checks++;
      if (arr_en_cnt != 0 || obs_row_q.size() != 0) begin
         errors++; $display("FAIL kzero_no_compute got=%0d/%0d exp=0/0", arr_en_cnt, obs_row_q.size());
      end
   endtask

   task automatic test_ready_hold();
      do_pass(3, 0, -1, 0, 0, 2, 5, 1'b0, -1, "rdyhold");
      checks++;
      if (rd_cycles != 9) begin
         errors++; $display("FAIL rdyhold_cycles got=%0d exp=9", rd_cycles);
      end
   endtask

   task automatic test_start_ignored();
      do_pass(4, 0, -1, 0, 0, -1, 0, 1'b1, -1, "startmid");
      checks++;
      if (obs_row_q.size() != 10) begin
         errors++; $display("FAIL startmid_len got=%0d exp=10", obs_row_q.size());
      end
   endtask

   task automatic test_mid_reset();
      do_pass(6, 0, -1, 0, 0, -1, 0, 1'b0, 5, "midrst");
   endtask

   task automatic test_random();
      int k;
      for (int n = 0; n < 12; n++) begin
         k = (n == 11) ? 255 : int'($urandom_range(20));
         do_pass(k, 30, -1, 0, 30, -1, 0, 1'($urandom), -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_k_zero();
      test_ready_hold();
      test_start_ignored();
      test_mid_reset();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic test_back_to_back();
      do_pass(2, 0, -1, 0, 0, -1, 0, 1'b0, -1, "b2b_a");
      do_pass(5, 20, -1, 0, 20, -1, 0, 1'b0, -1, "b2b_b");
   endtask

endmodule

// File: doc/systolic_array_controller.md
Name: systolic_array_controller

Overview:
Sequences one matrix-multiply pass on a ROWS x COLS grid of multiply-accumulate processing elements. For each pass it:
- clears the PE accumulators;
- streams K operand steps with row/column skew, stalling on operand availability;
- reads the accumulated results out row by row through a valid/ready handshake.

It sits between the operand buffers (input/weight SRAMs) and the PE array, driving the array's EN and clear inputs.

Parameters:
ROWS, 4, number of PE rows (input operands enter from the left, one per row)
COLS, 4, number of PE columns (weights enter from the top, one per column)
KW, 8, width of the inner-dimension length and operand read address

Ports:
CLK  input  1  clock
SYNC_RST  input  1  synchronous active-high reset
START  input  1  request a pass; sampled only in IDLE
K_LEN  input  KW  inner dimension K; captured on accepted START
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse when the pass completes
OP_RD_EN  output  1  operand buffer read request
OP_RD_ADDR  output  KW+$clog2(ROWS+COLS)  skew step index t
OP_VALID  input  1  operand buffers present data for step t this cycle
ROW_MASK  output  ROWS  bit i=1: row i input lane carries real data, else buffer drives 0
COL_MASK  output  COLS  bit j=1: column j weight lane carries real data, else 0
ARR_EN  output  1  PE array enable
ARR_CLR  output  1  PE array accumulator clear (drives PE SYNC_RST)
RES_ROW  output  $clog2(ROWS)  result row currently presented
RES_VALID  output  1  result row valid
RES_READY  input  1  downstream accepts result row

Behaviour:
- Reset: state=IDLE, t=0, K register=0, RES_ROW=0. All outputs 0: BUSY, DONE, OP_RD_EN, ARR_EN, ARR_CLR, RES_VALID, masks.
- Reset has priority over every other event. Reset mid-pass abandons the pass and returns to IDLE next cycle with no DONE pulse.
- States: IDLE, CLEAR, COMPUTE, READOUT, FINISH.
- IDLE: on START=1, capture K_LEN and go to CLEAR. A START in any other state is ignored.
- CLEAR: exactly one cycle with ARR_CLR=1 and t<=0.
  - Next state is COMPUTE, or READOUT if K=0 (READOUT then returns all-zero results).
- COMPUTE:
  - T = K+ROWS+COLS-2 steps, t = 0..T-1.
  - OP_RD_EN=1 and OP_RD_ADDR=t.
  - ARR_EN = OP_VALID; t increments only when OP_VALID=1.
  - OP_VALID=0 is a stall: t, masks and the array hold, and ARR_EN=0.
  - Go to READOUT on the valid step with t=T-1.
- Skew masks:
  - ROW_MASK[i] = (t>=i) && (t-i<K).
  - COL_MASK[j] = (t>=j) && (t-j<K).
  - Both are zero outside COMPUTE.
- ARR_EN, ARR_CLR, OP_RD_EN and the masks are combinational decodes of registered state/t/K. Zero added latency.
- READOUT:
  - RES_VALID=1, RES_ROW starts at 0.
  - Advance on RES_VALID&&RES_READY.
  - The handshake on RES_ROW=ROWS-1 goes to FINISH.
  - RES_READY low holds RES_ROW indefinitely. ARR_EN stays 0, so PE results are stable.
- FINISH: DONE=1 for one cycle, then IDLE. BUSY=0 in the FINISH→IDLE cycle's successor.
- Arithmetic: t counts to at most 2^KW+ROWS+COLS-3 without overflow (hence the widened address).
- START asserted in the same cycle DONE pulses is ignored. The next START is sampled in IDLE.

Optional Feature:
Macro SA_CTRL_PERF_CNT_EN.
- Defined: adds output STALL_CNT [15:0]. It counts COMPUTE cycles with OP_VALID=0, saturates at 16'hFFFF, clears on accepted START and on SYNC_RST, and holds value after DONE.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Package sa_ctrl_pkg holds:
  - state enum typedef (IDLE, CLEAR, COMPUTE, READOUT, FINISH);
  - localparam functions for step-counter width and T computation.
- Sub-module sa_skew_mask (parameter N, inputs t and K, output N-bit mask) is instantiated twice, for rows (N=ROWS) and columns (N=COLS).

Test Plan:
- ROWS=COLS=4, K_LEN=3, OP_VALID=1 constant, START pulse → ARR_CLR high 1 cycle, then ARR_EN high exactly 9 cycles with ROW_MASK 0001,0011,0111,1110,1100,1000,0000,0000,0000. Then RES_VALID with RES_ROW 0..3, then DONE 1 cycle.
- Same pass with OP_VALID low for 2 cycles at t=4 → t holds at 4, ARR_EN=0 and masks stable for those 2 cycles. Total COMPUTE = 11 cycles; with SA_CTRL_PERF_CNT_EN, STALL_CNT=2.
- K_LEN=0 → CLEAR then READOUT directly. ARR_EN never asserted. 4 result rows, then DONE.
- READOUT with RES_READY low 5 cycles at RES_ROW=2 → RES_ROW stays 2, RES_VALID stays 1, no DONE until 2 more handshakes.
- START during COMPUTE with different K_LEN → ignored; T unchanged. SYNC_RST at t=5 → next cycle IDLE, all outputs 0, no DONE.
